// File: rtl/debug_unit_uart_if.sv
// UART byte channel between the debug engine and the UART RX/TX pair.
// master: the debug engine (consumes RX, produces TX).
// slave: the UART side.
interface debug_unit_uart_if #(
   parameter int unsigned NB_DATA = 8
);
   logic               rx_done;
   logic [NB_DATA-1:0] rx_data;
   logic               tx_done;
   logic [NB_DATA-1:0] tx_data;
   logic               tx_start;

   modport master (
      input  rx_done, rx_data, tx_done,
      output tx_data, tx_start
   );

   modport slave (
      output rx_done, rx_data, tx_done,
      input  tx_data, tx_start
   );
endinterface

// File: rtl/debug_unit_uart.sv
// UART command/response debug engine for the pipelined MIPS core.
// It loads program words into instruction memory and runs the pipeline in
// continuous or single-step mode, with an optional PC breakpoint.
// On every stop it streams a dump frame: latches, then registers, then data memory.
// Optional feature macro: DEBUG_CHECKSUM_EN appends an XOR checksum byte to each dump frame.
module debug_unit_uart #(
   parameter int unsigned NB_DATA      = 8,
   parameter int unsigned NB_WORD      = 32,
   parameter int unsigned NB_LATCHES   = 350,
   parameter int unsigned NB_REG_ADDR  = 5,
   parameter int unsigned NB_DMEM_ADDR = 5
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   debug_unit_uart_if.master       uart,
   input  logic [NB_LATCHES-1:0]   i_latches,
   input  logic [NB_WORD-1:0]      i_pc,
   input  logic                    i_end,
   input  logic [NB_WORD-1:0]      i_r_data_registers,
   input  logic [NB_WORD-1:0]      i_r_data_data_mem,
   output logic [NB_REG_ADDR-1:0]  o_r_addr_registers,
   output logic [NB_DMEM_ADDR-1:0] o_r_addr_data_mem,
   output logic                    o_reset_pipeline,
   output logic                    o_stop,
   output logic                    o_write_instruction_mem,
   output logic [NB_WORD-1:0]      o_instruction_mem_addr,
   output logic [NB_WORD-1:0]      o_instruction_mem_data
);

   localparam int unsigned K          = NB_WORD / NB_DATA;
   localparam int unsigned N_REGS     = 2 ** NB_REG_ADDR;
   localparam int unsigned N_DMEM     = 2 ** NB_DMEM_ADDR;
   localparam int unsigned N_LAT_B    = (NB_LATCHES + NB_DATA - 1) / NB_DATA;
   localparam int unsigned NB_LAT_PAD = N_LAT_B * NB_DATA;
   localparam int unsigned NB_SHIFT   = (NB_LAT_PAD > NB_WORD) ? NB_LAT_PAD : NB_WORD;
   localparam int unsigned N_MAXB     = (N_LAT_B > K) ? N_LAT_B : K;
   localparam int unsigned NB_BCNT    = $clog2(N_MAXB + 1);
   localparam int unsigned NB_WCNT    = $clog2(K + 1);
   localparam int unsigned NB_IDX     = (NB_REG_ADDR > NB_DMEM_ADDR) ? NB_REG_ADDR : NB_DMEM_ADDR;
   localparam int unsigned ADDR_STEP  = NB_WORD / 8;

   localparam logic [NB_DATA-1:0] OP_LOAD        = NB_DATA'(8'h00);
   localparam logic [NB_DATA-1:0] OP_START_CONT  = NB_DATA'(8'h01);
   localparam logic [NB_DATA-1:0] OP_START_DEBUG = NB_DATA'(8'h02);
   localparam logic [NB_DATA-1:0] OP_STEP        = NB_DATA'(8'h03);
   localparam logic [NB_DATA-1:0] OP_END_DEBUG   = NB_DATA'(8'h04);
   localparam logic [NB_DATA-1:0] OP_SET_BREAK   = NB_DATA'(8'h05);
   localparam logic [NB_DATA-1:0] OP_CLR_BREAK   = NB_DATA'(8'h06);
   localparam logic [NB_DATA-1:0] REPLY_ERR      = NB_DATA'(8'hEE);

   typedef enum logic [3:0] {
      IDLE, LOAD, RUN, DEBUG, STEP, BRK_LOAD, DUMP_SETUP, DUMP_TX, DUMP_WAIT
   } state_t;

   typedef enum logic [1:0] {SEC_LAT, SEC_REG, SEC_MEM, SEC_CHK} sec_t;

   state_t                  state_q, state_d;
   sec_t                    sec_q, sec_d;
   logic                    rst_pipe_q, rst_pipe_d;
   logic                    stop_q, stop_d;
   logic [NB_DATA-1:0]      tx_data_q, tx_data_d;
   logic                    tx_start_q, tx_start_d;
   logic                    wr_en_q, wr_en_d;
   logic [NB_WORD-1:0]      im_addr_q, im_addr_d;
   logic [NB_WORD-1:0]      im_data_q, im_data_d;
   logic [NB_WORD-1:0]      load_addr_q, load_addr_d;
   logic [NB_WORD-1:0]      word_q, word_d;
   logic [NB_WCNT-1:0]      wcnt_q, wcnt_d;
   logic [NB_WORD-1:0]      bp_q, bp_d;
   logic                    bp_valid_q, bp_valid_d;
   logic                    brk_ret_dbg_q, brk_ret_dbg_d;
   logic [NB_REG_ADDR-1:0]  rd_reg_q, rd_reg_d;
   logic [NB_DMEM_ADDR-1:0] rd_mem_q, rd_mem_d;
   logic [NB_IDX-1:0]       idx_q, idx_d;
   logic [NB_BCNT-1:0]      bcnt_q, bcnt_d;
   logic [NB_SHIFT-1:0]     shift_q, shift_d;
   logic                    load_pend_q, load_pend_d;
   logic                    exit_idle_q, exit_idle_d;
`ifdef DEBUG_CHECKSUM_EN
   logic [NB_DATA-1:0]      chk_q, chk_d;
`endif

   logic [NB_WORD-1:0]      new_word;
   logic                    last_byte;
   logic [NB_SHIFT-1:0]     cur;
   logic                    err;
   logic                    start_dump;
   logic                    finish;

   // incoming byte shifted into the word under assembly, MSB first
   assign new_word  = NB_WORD'({word_q, uart.rx_data});
   assign last_byte = (wcnt_q == NB_WCNT'(K - 1));

   // next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      sec_d         = sec_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      wr_en_d       = 1'b0;
      im_addr_d     = im_addr_q;
      im_data_d     = im_data_q;
      load_addr_d   = load_addr_q;
      word_d        = word_q;
      wcnt_d        = wcnt_q;
      bp_d          = bp_q;
      bp_valid_d    = bp_valid_q;
      brk_ret_dbg_d = brk_ret_dbg_q;
      rd_reg_d      = rd_reg_q;
      rd_mem_d      = rd_mem_q;
      idx_d         = idx_q;
      bcnt_d        = bcnt_q;
      shift_d       = shift_q;
      load_pend_d   = load_pend_q;
      exit_idle_d   = exit_idle_q;
`ifdef DEBUG_CHECKSUM_EN
      chk_d         = chk_q;
`endif
      cur           = shift_q;
      err           = 1'b0;
      start_dump    = 1'b0;
      finish        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (uart.rx_done) begin
               unique case (uart.rx_data)
                  OP_LOAD: begin
                     state_d     = LOAD;
                     load_addr_d = '0;
                     wcnt_d      = '0;
                  end
                  OP_START_CONT:  state_d = RUN;
                  OP_START_DEBUG: state_d = DEBUG;
                  OP_SET_BREAK: begin
                     state_d       = BRK_LOAD;
                     brk_ret_dbg_d = 1'b0;
                     wcnt_d        = '0;
                  end
                  OP_CLR_BREAK:   bp_valid_d = 1'b0;
                  default:        err = 1'b1;
               endcase
            end
         end
         LOAD: begin
            if (uart.rx_done) begin
               word_d = new_word;
               if (last_byte) begin
                  wcnt_d      = '0;
                  wr_en_d     = 1'b1;
                  im_addr_d   = load_addr_q;
                  im_data_d   = new_word;
                  load_addr_d = load_addr_q + NB_WORD'(ADDR_STEP);
                  if (&new_word) state_d = IDLE;
               end else begin
                  wcnt_d = wcnt_q + NB_WCNT'(1);
               end
            end
         end
         RUN: begin
            if (i_end || (bp_valid_q && (i_pc == bp_q))) begin
               start_dump  = 1'b1;
               exit_idle_d = 1'b1;
            end
         end
         DEBUG: begin
            if (uart.rx_done) begin
               unique case (uart.rx_data)
                  OP_STEP:      state_d = STEP;
                  OP_END_DEBUG: state_d = IDLE;
                  OP_SET_BREAK: begin
                     state_d       = BRK_LOAD;
                     brk_ret_dbg_d = 1'b1;
                     wcnt_d        = '0;
                  end
                  OP_CLR_BREAK: bp_valid_d = 1'b0;
                  default:      err = 1'b1;
               endcase
            end
         end
         STEP: begin
            start_dump  = 1'b1;
            exit_idle_d = i_end;
         end
         BRK_LOAD: begin
            if (uart.rx_done) begin
               word_d = new_word;
               if (last_byte) begin
                  wcnt_d     = '0;
                  bp_d       = new_word;
                  bp_valid_d = 1'b1;
                  state_d    = brk_ret_dbg_q ? DEBUG : IDLE;
               end else begin
                  wcnt_d = wcnt_q + NB_WCNT'(1);
               end
            end
         end
         DUMP_SETUP: begin
            state_d = DUMP_TX;
            unique case (sec_q)
               SEC_LAT: begin
                  shift_d     = NB_SHIFT'(i_latches) << (NB_SHIFT - NB_LAT_PAD);
                  bcnt_d      = NB_BCNT'(N_LAT_B);
                  load_pend_d = 1'b0;
               end
               SEC_REG: begin
                  rd_reg_d    = NB_REG_ADDR'(idx_q);
                  bcnt_d      = NB_BCNT'(K);
                  load_pend_d = 1'b1;
               end
               SEC_MEM: begin
                  rd_mem_d    = NB_DMEM_ADDR'(idx_q);
                  bcnt_d      = NB_BCNT'(K);
                  load_pend_d = 1'b1;
               end
               default: begin
`ifdef DEBUG_CHECKSUM_EN
                  shift_d = NB_SHIFT'(chk_q) << (NB_SHIFT - NB_DATA);
`endif
                  bcnt_d      = NB_BCNT'(1);
                  load_pend_d = 1'b0;
               end
            endcase
         end
         DUMP_TX: begin
            // read data arrives one cycle after the address was driven
            if (load_pend_q)
               cur = NB_SHIFT'((sec_q == SEC_REG) ? i_r_data_registers : i_r_data_data_mem)
                     << (NB_SHIFT - NB_WORD);
            shift_d     = cur;
            load_pend_d = 1'b0;
            tx_data_d   = cur[NB_SHIFT-1 -: NB_DATA];
            tx_start_d  = 1'b1;
`ifdef DEBUG_CHECKSUM_EN
            chk_d       = chk_q ^ cur[NB_SHIFT-1 -: NB_DATA];
`endif
            state_d     = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            if (uart.tx_done) begin
               shift_d = shift_q << NB_DATA;
               if (bcnt_q == NB_BCNT'(1)) begin
                  state_d = DUMP_SETUP;
                  unique case (sec_q)
                     SEC_LAT: begin
                        sec_d = SEC_REG;
                        idx_d = '0;
                     end
                     SEC_REG: begin
                        if (idx_q == NB_IDX'(N_REGS - 1)) begin
                           sec_d = SEC_MEM;
                           idx_d = '0;
                        end else begin
                           idx_d = idx_q + NB_IDX'(1);
                        end
                     end
                     SEC_MEM: begin
                        if (idx_q == NB_IDX'(N_DMEM - 1)) begin
`ifdef DEBUG_CHECKSUM_EN
                           sec_d = SEC_CHK;
`else
                           finish = 1'b1;
`endif
                        end else begin
                           idx_d = idx_q + NB_IDX'(1);
                        end
                     end
                     default: finish = 1'b1;
                  endcase
               end else begin
                  bcnt_d  = bcnt_q - NB_BCNT'(1);
                  state_d = DUMP_TX;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (finish) state_d = exit_idle_q ? IDLE : DEBUG;

      if (start_dump) begin
         state_d = DUMP_SETUP;
         sec_d   = SEC_LAT;
         idx_d   = '0;
`ifdef DEBUG_CHECKSUM_EN
         chk_d   = '0;
`endif
      end

      if (err) begin
         tx_data_d  = REPLY_ERR;
         tx_start_d = 1'b1;
      end

      rst_pipe_d = (state_d == IDLE) || ((state_d == BRK_LOAD) && !brk_ret_dbg_d);
      stop_d     = !((state_d == RUN) || (state_d == STEP));
   end

   // state and output registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= IDLE;
         sec_q         <= SEC_LAT;
         rst_pipe_q    <= 1'b1;
         stop_q        <= 1'b1;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         wr_en_q       <= 1'b0;
         im_addr_q     <= '0;
         im_data_q     <= '0;
         load_addr_q   <= '0;
         word_q        <= '0;
         wcnt_q        <= '0;
         bp_q          <= '0;
         bp_valid_q    <= 1'b0;
         brk_ret_dbg_q <= 1'b0;
         rd_reg_q      <= '0;
         rd_mem_q      <= '0;
         idx_q         <= '0;
         bcnt_q        <= '0;
         shift_q       <= '0;
         load_pend_q   <= 1'b0;
         exit_idle_q   <= 1'b0;
`ifdef DEBUG_CHECKSUM_EN
         chk_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         sec_q         <= sec_d;
         rst_pipe_q    <= rst_pipe_d;
         stop_q        <= stop_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         wr_en_q       <= wr_en_d;
         im_addr_q     <= im_addr_d;
         im_data_q     <= im_data_d;
         load_addr_q   <= load_addr_d;
         word_q        <= word_d;
         wcnt_q        <= wcnt_d;
         bp_q          <= bp_d;
         bp_valid_q    <= bp_valid_d;
         brk_ret_dbg_q <= brk_ret_dbg_d;
         rd_reg_q      <= rd_reg_d;
         rd_mem_q      <= rd_mem_d;
         idx_q         <= idx_d;
         bcnt_q        <= bcnt_d;
         shift_q       <= shift_d;
         load_pend_q   <= load_pend_d;
         exit_idle_q   <= exit_idle_d;
`ifdef DEBUG_CHECKSUM_EN
         chk_q         <= chk_d;
`endif
      end
   end

   assign uart.tx_data            = tx_data_q;
   assign uart.tx_start           = tx_start_q;
   assign o_reset_pipeline        = rst_pipe_q;
   assign o_stop                  = stop_q;
   assign o_write_instruction_mem = wr_en_q;
   assign o_instruction_mem_addr  = im_addr_q;
   assign o_instruction_mem_data  = im_data_q;
   assign o_r_addr_registers      = rd_reg_q;
   assign o_r_addr_data_mem       = rd_mem_q;

endmodule
